// File: rtl/press_pulse.sv
// press_pulse
//   Debounces a synchronized push-button level and emits a single-cycle
//   press event for every accepted press. A level change is accepted only
//   after DEBOUNCE_CYCLES consecutive identical samples.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive stable samples needed to accept a change (1..255)
//
// Ports
//   clk    : system clock, rising edge
//   reset  : synchronous, active-high reset
//   din    : synchronized button level, 1 = pressed
//   enable : 1 = press events may be reported on pulse
//   pulse  : registered one-cycle press event
//   held   : registered debounced button level
module press_pulse #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  input  logic enable,
  output logic pulse,
  output logic held
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  // The qualifying edge is the one on which the counter would reach
  // DEBOUNCE_CYCLES, i.e. when it currently holds DEBOUNCE_CYCLES-1.
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    P_WAIT = 2'd1,
    HELD   = 2'd2,
    R_WAIT = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          pulse_nxt;
  logic          held_nxt;

  // State, counter and both outputs are registered together so pulse and
  // held change on the same edge as the state that implies them.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      pulse <= 1'b0;
      held  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      pulse <= pulse_nxt;
      held  <= held_nxt;
    end
  end

  // Next-state logic. The first sample that differs from the stable level
  // already counts as one, so the counter starts at 1 when qualification
  // begins. With a single-sample debounce the wait states are skipped.
  // A glitch during release qualification returns to HELD silently, since
  // the button never actually left the pressed level.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pulse_nxt = 1'b0;

    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (din) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_nxt = HELD;
            pulse_nxt = enable;
          end else begin
            state_nxt = P_WAIT;
            cnt_nxt   = CW'(1);
          end
        end
      end

      P_WAIT: begin
        if (!din) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == LAST) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
          pulse_nxt = enable;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end

      HELD: begin
        cnt_nxt = '0;
        if (!din) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = R_WAIT;
            cnt_nxt   = CW'(1);
          end
        end
      end

      R_WAIT: begin
        if (din) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else if (cnt == LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase

    held_nxt = (state_nxt == HELD) || (state_nxt == R_WAIT);
  end

endmodule

// File: tb/tb_press_pulse.sv
// tb_press_pulse
//   Directed bench for press_pulse. One instance uses a four-sample
//   debounce, a second uses a single-sample debounce; both share clock,
//   reset and enable.
module tb_press_pulse;

  logic clk;
  logic reset;
  logic din;
  logic din1;
  logic enable;
  logic pulse;
  logic held;
  logic pulse1;
  logic held1;

  int n_checks;
  int n_fail;

  press_pulse #(.DEBOUNCE_CYCLES(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .din    (din),
    .enable (enable),
    .pulse  (pulse),
    .held   (held)
  );

  press_pulse #(.DEBOUNCE_CYCLES(1)) dut1 (
    .clk    (clk),
    .reset  (reset),
    .din    (din1),
    .enable (enable),
    .pulse  (pulse1),
    .held   (held1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check pulse/held of the N=4 instance against expected values.
  task automatic chk4(input string name, input int idx, input logic ep, input logic eh);
    n_checks++;
    if (pulse !== ep) begin
      n_fail++;
      $display("[TB] FAIL %s[%0d] pulse: got %b expected %b", name, idx, pulse, ep);
    end
    n_checks++;
    if (held !== eh) begin
      n_fail++;
      $display("[TB] FAIL %s[%0d] held: got %b expected %b", name, idx, held, eh);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; din = 1'b1; din1 = 1'b1; enable = 1'b1;
    tick();
    tick();
    chk4("reset", 0, 1'b0, 1'b0);
    n_checks++;
    if (pulse1 !== 1'b0 || held1 !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_n1 pulse/held: got %b/%b expected 0/0", pulse1, held1);
    end
    reset = 1'b0; din = 1'b0; din1 = 1'b0;
    tick();
    chk4("reset_release", 0, 1'b0, 1'b0);
  endtask

  task automatic test_press();
    din = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk4("press", i, (i == 4), (i >= 4));
    end
    din = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk4("release", i, 1'b0, (i < 4));
    end
  endtask

  task automatic test_bounce();
    logic [8:0] pat;
    pat = 9'b001110111;
    for (int i = 0; i < 9; i++) begin
      din = pat[i];
      tick();
      chk4("bounce", i, 1'b0, 1'b0);
    end
  endtask

  task automatic test_release_glitch();
    logic [2:0] pat;
    din = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk4("glitch_press", i, (i == 4), (i == 4));
    end
    pat = 3'b100;
    for (int i = 0; i < 3; i++) begin
      din = pat[i];
      tick();
      chk4("glitch_rel", i, 1'b0, 1'b1);
    end
    din = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk4("glitch_final", i, 1'b0, (i < 4));
    end
  endtask

  task automatic test_enable_gate();
    enable = 1'b0;
    din = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk4("en_off", i, 1'b0, (i == 4));
    end
    enable = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk4("en_rise", i, 1'b0, 1'b1);
    end
    din = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk4("en_release", i, 1'b0, (i < 4));
    end
    din = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk4("en_repress", i, (i == 4), (i == 4));
    end
    din = 1'b0;
    for (int i = 1; i <= 4; i++) tick();
    chk4("en_idle", 0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    din = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      tick();
      chk4("rmid_pre", i, 1'b0, 1'b0);
    end
    reset = 1'b1;
    tick();
    chk4("rmid_reset", 0, 1'b0, 1'b0);
    reset = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk4("rmid_post", i, (i == 4), (i >= 4));
    end
    din = 1'b0;
    for (int i = 1; i <= 4; i++) tick();
    chk4("rmid_idle", 0, 1'b0, 1'b0);
  endtask

  task automatic test_n1();
    logic [3:0] pat;
    pat = 4'b0101;
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din1 = pat[i];
      tick();
      n_checks++;
      if (pulse1 !== pat[i]) begin
        n_fail++;
        $display("[TB] FAIL n1[%0d] pulse: got %b expected %b", i, pulse1, pat[i]);
      end
      n_checks++;
      if (held1 !== pat[i]) begin
        n_fail++;
        $display("[TB] FAIL n1[%0d] held: got %b expected %b", i, held1, pat[i]);
      end
    end
    din1 = 1'b1;
    tick();
    tick();
    n_checks++;
    if (pulse1 !== 1'b0 || held1 !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL n1_hold pulse/held: got %b/%b expected 0/1", pulse1, held1);
    end
    din1 = 1'b0;
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_press();
    test_bounce();
    test_release_glitch();
    test_enable_gate();
    test_reset_mid();
    test_n1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
